// File: rtl/bp_pht_controller_if.sv
// Lookup, feedback-update and SRAM-port signal bundle for bp_pht_controller.
// The slave modport is the controller side; the master modport is the pipeline/SRAM side.
interface bp_pht_controller_if #(
  parameter int IDX_W = 10,
  parameter int CNT_W = 2
);
  logic             i_lkp_valid;
  logic [IDX_W-1:0] i_lkp_index;
  logic             o_lkp_ready;
  logic             o_lkp_valid;
  logic             o_lkp_taken;
  logic             i_upd_valid;
  logic [IDX_W-1:0] i_upd_index;
  logic             i_upd_outcome;
  logic             o_upd_ready;
  logic             o_mem_en;
  logic             o_mem_we;
  logic [IDX_W-1:0] o_mem_addr;
  logic [CNT_W-1:0] o_mem_wdata;
  logic [CNT_W-1:0] i_mem_rdata;
  logic             o_init_busy;

  modport slave (
    input  i_lkp_valid, i_lkp_index, i_upd_valid, i_upd_index, i_upd_outcome, i_mem_rdata,
    output o_lkp_ready, o_lkp_valid, o_lkp_taken, o_upd_ready,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_init_busy
  );

  modport master (
    output i_lkp_valid, i_lkp_index, i_upd_valid, i_upd_index, i_upd_outcome, i_mem_rdata,
    input  o_lkp_ready, o_lkp_valid, o_lkp_taken, o_upd_ready,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_init_busy
  );
endinterface

// File: rtl/bp_pht_controller.sv
// Single-port PHT SRAM sequencer: post-reset clear, lookup/update arbitration, queued RMW updates.
// Optional statistics counters are enabled with the BP_PHT_PERF_CNT_EN macro.
module bp_pht_controller #(
  parameter int IDX_W        = 10,
  parameter int CNT_W        = 2,
  parameter int INIT_VAL     = 1,
  parameter int Q_DEPTH      = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bp_pht_controller_if.slave pht_if
`ifdef BP_PHT_PERF_CNT_EN
  ,
  output logic [31:0]        o_stat_lookups,
  output logic [31:0]        o_stat_updates,
  output logic [31:0]        o_stat_starve
`endif
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [PTR_W:0]   Q_FULL   = Q_DEPTH[PTR_W:0];
  localparam logic [SW-1:0]    S_LIMIT  = STARVE_LIMIT[SW-1:0];
  localparam logic [CNT_W-1:0] INIT_CNT = INIT_VAL[CNT_W-1:0];

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPD_WR} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             lkp_vld_q, lkp_vld_d;

  logic [IDX_W-1:0] q_idx_q [Q_DEPTH];
  logic             q_out_q [Q_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic             q_full, q_empty, push, pop;
  logic             grant, starved;
  logic             mem_en, mem_we;
  logic [IDX_W-1:0] mem_addr;
  logic [CNT_W-1:0] mem_wdata;
  logic [CNT_W-1:0] rmw_data;
  logic [IDX_W-1:0] head_idx;
  logic             head_out;

  assign q_full   = (count_q == Q_FULL);
  assign q_empty  = (count_q == '0);
  assign push     = pht_if.i_upd_valid & ~q_full;
  assign head_idx = q_idx_q[rd_ptr_q];
  assign head_out = q_out_q[rd_ptr_q];

  always_comb begin
    rmw_data = pht_if.i_mem_rdata;
    if (head_out) begin
      if (pht_if.i_mem_rdata != '1) rmw_data = pht_if.i_mem_rdata + CNT_W'(1);
    end else begin
      if (pht_if.i_mem_rdata != '0) rmw_data = pht_if.i_mem_rdata - CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    starve_d  = starve_q;
    lkp_vld_d = 1'b0;
    grant     = 1'b0;
    starved   = 1'b0;
    pop       = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = clr_ptr_q;
    mem_wdata = INIT_CNT;
    case (state_q)
      ST_INIT: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + IDX_W'(1);
        if (clr_ptr_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        starved = pht_if.i_lkp_valid & (starve_q >= S_LIMIT);
        if (pht_if.i_lkp_valid && (starve_q < S_LIMIT)) begin
          grant     = 1'b1;
          mem_en    = 1'b1;
          mem_addr  = pht_if.i_lkp_index;
          lkp_vld_d = 1'b1;
          if (!q_empty) starve_d = starve_q + SW'(1);
        end else if (!q_empty) begin
          mem_en   = 1'b1;
          mem_addr = head_idx;
          starve_d = '0;
          state_d  = ST_UPD_WR;
        end
      end
      ST_UPD_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = head_idx;
        mem_wdata = rmw_data;
        pop       = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // SRAM strobes are gated by rst_n so an abandoned clear or RMW stops touching the array at once.
  assign pht_if.o_mem_en    = mem_en & rst_n;
  assign pht_if.o_mem_we    = mem_we & rst_n;
  assign pht_if.o_mem_addr  = mem_addr;
  assign pht_if.o_mem_wdata = mem_wdata;
  assign pht_if.o_lkp_ready = grant;
  assign pht_if.o_lkp_valid = lkp_vld_q;
  assign pht_if.o_lkp_taken = lkp_vld_q & pht_if.i_mem_rdata[CNT_W-1];
  assign pht_if.o_upd_ready = ~q_full;
  assign pht_if.o_init_busy = (state_q == ST_INIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_ptr_q <= '0;
      starve_q  <= '0;
      lkp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      starve_q  <= starve_d;
      lkp_vld_q <= lkp_vld_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Queue payload needs no reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx_q[wr_ptr_q] <= pht_if.i_upd_index;
      q_out_q[wr_ptr_q] <= pht_if.i_upd_outcome;
    end
  end

`ifdef BP_PHT_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_lookups <= '0;
      o_stat_updates <= '0;
      o_stat_starve  <= '0;
    end else begin
      if (grant)                o_stat_lookups <= o_stat_lookups + 32'd1;
      if (state_q == ST_UPD_WR) o_stat_updates <= o_stat_updates + 32'd1;
      if (starved)              o_stat_starve  <= o_stat_starve + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_pht_controller.sv
// Directed bench for bp_pht_controller (IDX_W=4) with an SRAM model and lookup/write scoreboards.
module tb_bp_pht_controller;

  localparam int IDX_W = 4;
  localparam int CNT_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int passCount  = 0;
  int checkCount = 0;
  int initAddr   = 0;

  typedef struct packed {
    logic [IDX_W-1:0] addr;
    logic [CNT_W-1:0] data;
  } wr_t;

  logic             lkpExpQ [$];
  wr_t              wrExpQ  [$];
  logic [CNT_W-1:0] refCnt  [16];
  logic [CNT_W-1:0] sram    [16];

  logic sReady, sBusy, sMemEn, sMemWe, sUpdReady;
  logic lg, ua;

  bp_pht_controller_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) pht_if ();

`ifdef BP_PHT_PERF_CNT_EN
  logic [31:0] statLookups, statUpdates, statStarve;
`endif

  bp_pht_controller #(
    .IDX_W(IDX_W), .CNT_W(CNT_W), .INIT_VAL(1), .Q_DEPTH(4), .STARVE_LIMIT(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pht_if(pht_if.slave)
`ifdef BP_PHT_PERF_CNT_EN
    ,
    .o_stat_lookups(statLookups),
    .o_stat_updates(statUpdates),
    .o_stat_starve (statStarve)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pht_if.o_mem_en) begin
      if (pht_if.o_mem_we) sram[pht_if.o_mem_addr] <= pht_if.o_mem_wdata;
      else                 pht_if.i_mem_rdata <= sram[pht_if.o_mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [CNT_W-1:0] satNext(input logic [CNT_W-1:0] c, input logic taken);
    if (taken) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  // Every lookup result and every post-clear SRAM write is matched against the scoreboards.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pht_if.o_lkp_valid) begin
        checkOutput("lkp_expected", 32'(lkpExpQ.size() != 0), 32'd1);
        if (lkpExpQ.size() != 0) checkOutput("lkp_taken", 32'(pht_if.o_lkp_taken), 32'(lkpExpQ.pop_front()));
      end
      if (pht_if.o_mem_en && pht_if.o_mem_we) begin
        if (pht_if.o_init_busy) begin
          checkOutput("init_addr", 32'(pht_if.o_mem_addr), 32'(initAddr));
          checkOutput("init_data", 32'(pht_if.o_mem_wdata), 32'd1);
          initAddr++;
        end else begin
          checkOutput("wr_expected", 32'(wrExpQ.size() != 0), 32'd1);
          if (wrExpQ.size() != 0) begin
            wr_t e;
            e = wrExpQ.pop_front();
            checkOutput("wr_addr", 32'(pht_if.o_mem_addr), 32'(e.addr));
            checkOutput("wr_data", 32'(pht_if.o_mem_wdata), 32'(e.data));
          end
        end
      end
    end
  end

  // One clock of stimulus; grants and accepted updates are recorded into the scoreboards.
  task automatic applyStimulus(input logic lv, input logic [IDX_W-1:0] li,
                               input logic uv, input logic [IDX_W-1:0] ui, input logic uo,
                               output logic lkpGrant, output logic updAcc);
    pht_if.i_lkp_valid   = lv;
    pht_if.i_lkp_index   = li;
    pht_if.i_upd_valid   = uv;
    pht_if.i_upd_index   = ui;
    pht_if.i_upd_outcome = uo;
    @(negedge clk);
    sReady    = pht_if.o_lkp_ready;
    sBusy     = pht_if.o_init_busy;
    sMemEn    = pht_if.o_mem_en;
    sMemWe    = pht_if.o_mem_we;
    sUpdReady = pht_if.o_upd_ready;
    lkpGrant  = lv & sReady;
    updAcc    = uv & sUpdReady;
    if (lkpGrant) lkpExpQ.push_back(refCnt[li][CNT_W-1]);
    if (updAcc) begin
      refCnt[ui] = satNext(refCnt[ui], uo);
      wrExpQ.push_back('{addr: ui, data: refCnt[ui]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    logic g, a;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, g, a);
  endtask

  task automatic sendUpdate(input logic [IDX_W-1:0] idx, input logic outcome);
    logic g, a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) applyStimulus(1'b0, '0, 1'b1, idx, outcome, g, a);
    checkOutput("upd_accept_timeout", 32'(a), 32'd1);
  endtask

  task automatic doReset();
    pht_if.i_lkp_valid   = 1'b0;
    pht_if.i_lkp_index   = '0;
    pht_if.i_upd_valid   = 1'b0;
    pht_if.i_upd_index   = '0;
    pht_if.i_upd_outcome = 1'b0;
    rst_n = 1'b0;
    #1;
    lkpExpQ.delete();
    wrExpQ.delete();
    for (int i = 0; i < 16; i++) refCnt[i] = 2'd1;
    initAddr = 0;
    checkOutput("rst_init_busy", 32'(pht_if.o_init_busy), 32'd1);
    checkOutput("rst_mem_en", 32'(pht_if.o_mem_en), 32'd0);
    checkOutput("rst_lkp_valid", 32'(pht_if.o_lkp_valid), 32'd0);
    checkOutput("rst_lkp_taken", 32'(pht_if.o_lkp_taken), 32'd0);
    checkOutput("rst_upd_ready", 32'(pht_if.o_upd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    #2;
    doReset();

    // Clear phase: 16 busy cycles with lookups refused, then the first grant in cycle 17.
    for (int c = 1; c <= 16; c++) begin
      applyStimulus(1'b1, 4'd0, 1'b0, '0, 1'b0, lg, ua);
      checkOutput("init_busy", 32'(sBusy), 32'd1);
      checkOutput("init_lkp_ready", 32'(sReady), 32'd0);
    end
    applyStimulus(1'b1, 4'd0, 1'b0, '0, 1'b0, lg, ua);
    checkOutput("post_init_busy", 32'(sBusy), 32'd0);
    checkOutput("post_init_ready", 32'(lg), 32'd1);
    checkOutput("init_count", 32'(initAddr), 32'd16);

    applyStimulus(1'b1, 4'd5, 1'b0, '0, 1'b0, lg, ua);
    checkOutput("lkp5_grant", 32'(lg), 32'd1);
    idleCycles(2);
    sendUpdate(4'd5, 1'b1);
    sendUpdate(4'd5, 1'b1);
    idleCycles(6);
    applyStimulus(1'b1, 4'd5, 1'b0, '0, 1'b0, lg, ua);
    checkOutput("lkp5_again_grant", 32'(lg), 32'd1);
    idleCycles(2);

    for (int i = 0; i < 4; i++) sendUpdate(4'd3, 1'b1);
    for (int i = 0; i < 5; i++) sendUpdate(4'd3, 1'b0);
    idleCycles(12);

    // Starvation: a queued update forces a two-cycle lookup stall after 8 counted grants.
    applyStimulus(1'b1, 4'd9, 1'b1, 4'd12, 1'b1, lg, ua);
    checkOutput("starve_first_grant", 32'(lg), 32'd1);
    checkOutput("starve_upd_accept", 32'(ua), 32'd1);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b1, 4'd9, 1'b0, '0, 1'b0, lg, ua);
      checkOutput($sformatf("starve_grant_%0d", k), 32'(lg), 32'((k < 8 || k == 10) ? 1 : 0));
    end
    idleCycles(3);

    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 4'(7 + k), k[0], lg, ua);
      checkOutput($sformatf("fill_accept_%0d", k), 32'(ua), 32'((k < 4) ? 1 : 0));
    end
    for (int c = 6; c <= 16; c++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, lg, ua);
      checkOutput("fill_init_busy", 32'(sBusy), 32'd1);
    end
    for (int c = 17; c <= 24; c++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, lg, ua);
      checkOutput($sformatf("drain_en_%0d", c), 32'(sMemEn), 32'd1);
      checkOutput($sformatf("drain_we_%0d", c), 32'(sMemWe), 32'((c % 2 == 0) ? 1 : 0));
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, lg, ua);
    checkOutput("drain_done_en", 32'(sMemEn), 32'd0);

    // Reset landing in the write half of an RMW.
    sendUpdate(4'd2, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (pht_if.o_mem_we && !pht_if.o_init_busy) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("rmw_write_seen", 32'(found), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrmw_mem_en", 32'(pht_if.o_mem_en), 32'd0);
    checkOutput("midrmw_init_busy", 32'(pht_if.o_init_busy), 32'd1);
    doReset();
    for (int c = 1; c <= 16; c++) idleCycles(1);
    checkOutput("reinit_count", 32'(initAddr), 32'd16);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, lg, ua);
      checkOutput("reinit_queue_empty", 32'(sMemEn), 32'd0);
    end

    checkOutput("lkp_scoreboard_drained", 32'(lkpExpQ.size()), 32'd0);
    checkOutput("wr_scoreboard_drained", 32'(wrExpQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
